// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer: state encoding,
// block/word widths and the default AES-128 round count.
package aes_seq_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_WORD_W    = 32;
  localparam int AES128_ROUNDS = 10;
  localparam int RND_W         = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    CAPT  = 3'd3,
    DONE  = 3'd4
  } aes_seq_state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [AES_WORD_W-1:0] block_word(
    input logic [AES_BLOCK_W-1:0] blk,
    input int                     idx
  );
    return blk[AES_BLOCK_W-1-idx*AES_WORD_W -: AES_WORD_W];
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in / result-out stream bundle of the AES round sequencer.
interface aes_round_sequencer_if;
  import aes_seq_pkg::*;

  // Both streams use valid/ready: a transfer happens on a rising clk edge
  // where valid and ready are both high; once valid is raised the source
  // holds it and its data unchanged until that transfer.
  logic                   in_valid;
  logic                   in_ready;
  logic [AES_BLOCK_W-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [AES_BLOCK_W-1:0] data_out;
  logic [AES_WORD_W-1:0]  data_out1;
  logic [AES_WORD_W-1:0]  data_out2;
  logic [AES_WORD_W-1:0]  data_out3;
  logic [AES_WORD_W-1:0]  data_out4;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, data_out1, data_out2, data_out3, data_out4
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, data_out1, data_out2, data_out3, data_out4
  );

endinterface

// File: rtl/aes_round_counter.sv
// Round (rnd) and sub-cycle (sub) counters for the AES round sequencer;
// produces the per-round step pulse and the last-round flag.
module aes_round_counter
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int ROUND_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic             run,
  output logic [RND_W-1:0] rnd,
  output logic             step,
  output logic             last,
  output logic             final_step
);

  localparam int SUB_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  logic [SUB_W-1:0] sub;

  assign step       = run && (sub == SUB_W'(ROUND_CYCLES - 1));
  assign last       = run && (rnd == RND_W'(NUM_ROUNDS));
  assign final_step = step && last;

  // rnd returns to 0 after the final step so dp_round reads 0 outside a job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rnd <= '0;
      sub <= '0;
    end else if (clear) begin
      rnd <= '0;
      sub <= '0;
    end else if (start) begin
      rnd <= RND_W'(1);
      sub <= '0;
    end else if (run) begin
      if (step) begin
        sub <= '0;
        rnd <= final_step ? '0 : rnd + RND_W'(1);
      end else begin
        sub <= sub + SUB_W'(1);
      end
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES-128 round datapath (no cipher logic).
// Optional build macro AES_SEQ_ZEROIZE_EN adds a synchronous zeroize input.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_ROUNDS,
  parameter int ROUND_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef AES_SEQ_ZEROIZE_EN
  input  logic                   zeroize,
`endif
  aes_round_sequencer_if.slave   bus,
  output logic [AES_BLOCK_W-1:0] dp_state_in,
  output logic                   dp_load,
  output logic                   dp_step,
  output logic [RND_W-1:0]       dp_round,
  output logic                   dp_last,
  input  logic [AES_BLOCK_W-1:0] dp_state_out,
  output logic                   busy,
  output aes_seq_state_t         dbg_state
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
    $error("aes_round_sequencer: NUM_ROUNDS must be 1..15");
  end
  if (ROUND_CYCLES < 1) begin : g_bad_cycles
    $error("aes_round_sequencer: ROUND_CYCLES must be >= 1");
  end

  aes_seq_state_t         state, next_state;
  logic                   in_ready_q;
  logic [AES_BLOCK_W-1:0] data_out_q;
  logic [RND_W-1:0]       rnd;
  logic                   rnd_step, rnd_last, final_step;
  logic                   accept, zap;

`ifdef AES_SEQ_ZEROIZE_EN
  localparam bit ZEROIZE_EN = 1'b1;
  assign zap = zeroize;
`else
  localparam bit ZEROIZE_EN = 1'b0;
  assign zap = 1'b0;
`endif

  assign accept = (state == IDLE) && bus.in_valid && in_ready_q;

  aes_round_counter #(
    .NUM_ROUNDS   (NUM_ROUNDS),
    .ROUND_CYCLES (ROUND_CYCLES)
  ) u_round_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (zap),
    .start      (state == LOAD),
    .run        (state == ROUND),
    .rnd        (rnd),
    .step       (rnd_step),
    .last       (rnd_last),
    .final_step (final_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = LOAD;
      LOAD:    next_state = ROUND;
      ROUND:   if (final_step) next_state = CAPT;
      CAPT:    next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (zap) next_state = IDLE;
  end

  // in_ready is registered from next_state so it is already high in the
  // first IDLE cycle and never depends combinationally on in_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready_q  <= 1'b0;
      dp_state_in <= '0;
      data_out_q  <= '0;
    end else begin
      in_ready_q <= (next_state == IDLE) && !zap;
      if (zap) begin
        dp_state_in <= '0;
        data_out_q  <= '0;
      end else begin
        if (accept) dp_state_in <= bus.data_in;
        if (state == CAPT) begin
          data_out_q <= dp_state_out;
        end else if (ZEROIZE_EN && (state == DONE) && bus.out_ready) begin
          data_out_q <= '0;
        end
      end
    end
  end

  assign dp_load  = (state == LOAD);
  assign dp_step  = rnd_step;
  assign dp_last  = rnd_last;
  assign dp_round = (state == ROUND) ? rnd : '0;
  assign busy     = (state != IDLE);
  assign dbg_state = state;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state == DONE);
  assign bus.data_out  = data_out_q;
  assign bus.data_out1 = block_word(data_out_q, 0);
  assign bus.data_out2 = block_word(data_out_q, 1);
  assign bus.data_out3 = block_word(data_out_q, 2);
  assign bus.data_out4 = block_word(data_out_q, 3);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: default instance plus a ROUND_CYCLES=3 instance,
// each with a behavioural datapath (load, +1 per step). Honours AES_SEQ_ZEROIZE_EN.
module tb_aes_round_sequencer;
  import aes_seq_pkg::*;

  localparam int NR = AES128_ROUNDS;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef AES_SEQ_ZEROIZE_EN
  logic zeroize;
`endif

  // ---------------- DUT A (defaults) ----------------
  aes_round_sequencer_if a_bus ();
  logic [127:0]   a_dp_in, a_dp_q;
  logic           a_dp_load, a_dp_step, a_dp_last, a_busy;
  logic [3:0]     a_dp_round;
  aes_seq_state_t a_state;

  aes_round_sequencer dut_a (
    .clk          (clk),
    .reset        (reset),
`ifdef AES_SEQ_ZEROIZE_EN
    .zeroize      (zeroize),
`endif
    .bus          (a_bus),
    .dp_state_in  (a_dp_in),
    .dp_load      (a_dp_load),
    .dp_step      (a_dp_step),
    .dp_round     (a_dp_round),
    .dp_last      (a_dp_last),
    .dp_state_out (a_dp_q),
    .busy         (a_busy),
    .dbg_state    (a_state)
  );

  always @(posedge clk) begin
    if (a_dp_load) a_dp_q <= a_dp_in;
    else if (a_dp_step) a_dp_q <= a_dp_q + 128'd1;
  end

  // ---------------- DUT B (ROUND_CYCLES=3) ----------------
  aes_round_sequencer_if b_bus ();
  logic [127:0]   b_dp_in, b_dp_q;
  logic           b_dp_load, b_dp_step, b_dp_last, b_busy;
  logic [3:0]     b_dp_round;
  aes_seq_state_t b_state;

  aes_round_sequencer #(.NUM_ROUNDS(NR), .ROUND_CYCLES(3)) dut_b (
    .clk          (clk),
    .reset        (reset),
`ifdef AES_SEQ_ZEROIZE_EN
    .zeroize      (zeroize),
`endif
    .bus          (b_bus),
    .dp_state_in  (b_dp_in),
    .dp_load      (b_dp_load),
    .dp_step      (b_dp_step),
    .dp_round     (b_dp_round),
    .dp_last      (b_dp_last),
    .dp_state_out (b_dp_q),
    .busy         (b_busy),
    .dbg_state    (b_state)
  );

  always @(posedge clk) begin
    if (b_dp_load) b_dp_q <= b_dp_in;
    else if (b_dp_step) b_dp_q <= b_dp_q + 128'd1;
  end

  // ---------------- protocol monitors ----------------
  int a_steps = 0, a_lasts = 0, last_bad = 0, excl_bad = 0, step_state_bad = 0, rdy_bad = 0;
  int b_steps = 0, b_prev = -1, b_gap_bad = 0;

  always @(negedge clk) begin
    if (a_dp_step) a_steps++;
    if (a_dp_last) begin
      a_lasts++;
      if (a_dp_round != 4'(NR)) last_bad++;
    end
    if (a_dp_step && a_dp_load) excl_bad++;
    if (a_dp_step && a_state != ROUND) step_state_bad++;
    if (a_bus.in_ready && a_state != IDLE) rdy_bad++;
    if (b_dp_load) b_prev = -1;
    if (b_dp_step) begin
      b_steps++;
      if (b_prev >= 0 && (cyc - b_prev) != 3) b_gap_bad++;
      b_prev = cyc;
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] src_q[$];
  int           acc_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input logic [127:0] blk, output int acc_cyc);
    int guard = 0;
    a_bus.in_valid = 1'b1;
    a_bus.data_in  = blk;
    while (!a_bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check("accept_wait_expired", 128'(guard >= 100), 128'd0);
    acc_cyc = cyc;
    tick();
    a_bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc_cyc, output int lat);
    int guard = 0;
    while (!a_bus.out_valid && guard < 400) begin
      tick();
      guard++;
    end
    lat = cyc - acc_cyc;
  endtask

  // Streams src_q through DUT A with random valid gaps and random out_ready.
  task automatic run_stream(input int n, input int valid_pct, input int ready_pct);
    int sent = 0, got = 0, guard = 0;
    while (got < n && guard < 3000) begin
      if (!a_bus.in_valid && sent < n && $urandom_range(1, 100) <= valid_pct) begin
        a_bus.in_valid = 1'b1;
        a_bus.data_in  = src_q[sent];
      end
      a_bus.out_ready = ($urandom_range(1, 100) <= ready_pct);
      if (a_bus.out_valid && a_bus.out_ready) begin
        if (exp_q.size() == 0) check("stream_spurious_result", a_bus.data_out, 128'd0 - 1);
        else check("stream_data", a_bus.data_out, exp_q.pop_front());
        got++;
      end
      if (a_bus.in_valid && a_bus.in_ready) begin
        exp_q.push_back(a_bus.data_in + 128'(NR));
        acc_q.push_back(cyc);
        sent++;
        tick();
        a_bus.in_valid = 1'b0;
      end else begin
        tick();
      end
      guard++;
    end
    check("stream_results", 128'(got), 128'(n));
    a_bus.out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, lat, s0, l0;
    logic [127:0] blk, exp;

    a_bus.in_valid = 1'b0; a_bus.out_ready = 1'b0; a_bus.data_in = '0;
    b_bus.in_valid = 1'b0; b_bus.out_ready = 1'b0; b_bus.data_in = '0;
`ifdef AES_SEQ_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_in_ready", a_bus.in_ready, 0);
    check("rst_out_valid", a_bus.out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_dp_load", a_dp_load, 0);
    check("rst_dp_round", a_dp_round, 0);
    check("rst_data_out", a_bus.data_out, 0);
    check("rst_dp_state_in", a_dp_in, 0);
    repeat (2) tick();
    check("rst_in_ready_held", a_bus.in_ready, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("rel_in_ready", a_bus.in_ready, 1);

    // Single block with the reference vector.
    blk = 128'h3243f6a8885a308d313198a2e0370734;
    a_bus.out_ready = 1'b1;
    s0 = a_steps; l0 = a_lasts;
    accept_block(blk, c0);
    check("single_load_value", a_dp_in, blk);
    wait_out(c0, lat);
    check("single_latency", 128'(lat), 128'd13);
    check("single_data", a_bus.data_out, 128'h3243f6a8885a308d313198a2e037073e);
    check("single_word1", a_bus.data_out1, 32'h3243f6a8);
    check("single_word2", a_bus.data_out2, 32'h885a308d);
    check("single_word3", a_bus.data_out3, 32'h313198a2);
    check("single_word4", a_bus.data_out4, 32'he037073e);
    check("single_steps", 128'(a_steps - s0), 128'd10);
    check("single_lasts", 128'(a_lasts - l0), 128'd1);
    tick();
    check("single_ov_fall", a_bus.out_valid, 0);
    check("single_in_ready", a_bus.in_ready, 1);
    a_bus.out_ready = 1'b0;

    // Backpressure: result held for 20 cycles.
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = blk + 128'(NR);
    accept_block(blk, c0);
    wait_out(c0, lat);
    check("bp_latency", 128'(lat), 128'd13);
    for (int i = 0; i < 20; i++) begin
      check("bp_data_stable", a_bus.data_out, exp);
      check("bp_in_ready_low", a_bus.in_ready, 0);
      check("bp_out_valid_held", a_bus.out_valid, 1);
      tick();
    end
    a_bus.out_ready = 1'b1;
    tick();
    a_bus.out_ready = 1'b0;
    check("bp_ov_fall", a_bus.out_valid, 0);
    check("bp_in_ready_rise", a_bus.in_ready, 1);
`ifdef AES_SEQ_ZEROIZE_EN
    check("bp_post_hs_data", a_bus.data_out, 128'd0);
`else
    check("bp_post_hs_data", a_bus.data_out, exp);
`endif

    // Back-to-back with in_valid held.
    src_q = {128'hAB348DF80C51984E2790436287AB34D1, 128'hACD670231AB1984E2790436287AB34D1};
    acc_q = {};
    run_stream(2, 100, 100);
    if (acc_q.size() == 2) check("b2b_spacing", 128'(acc_q[1] - acc_q[0]), 128'd14);
    else check("b2b_accepts", 128'(acc_q.size()), 128'd2);

    // Random gaps and backpressure.
    src_q = {};
    for (int i = 0; i < 6; i++) src_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    s0 = a_steps;
    run_stream(6, 60, 40);
    check("rand_steps", 128'(a_steps - s0), 128'(6 * NR));

    // Reset mid-ROUND, then a clean block.
    a_bus.out_ready = 1'b1;
    accept_block({$urandom(), $urandom(), $urandom(), $urandom()}, c0);
    for (int g = 0; g < 50 && a_dp_round != 4'd5; g++) tick();
    check("mid_round_reached", a_dp_round, 4'd5);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_in_ready", a_bus.in_ready, 0);
    check("mid_rst_dp_step", a_dp_step, 0);
    check("mid_rst_dp_round", a_dp_round, 0);
    check("mid_rst_dp_last", a_dp_last, 0);
    check("mid_rst_dp_state_in", a_dp_in, 0);
    check("mid_rst_data_out", a_bus.data_out, 0);
    check("mid_rst_out_valid", a_bus.out_valid, 0);
    @(negedge clk) reset = 1'b1;
    tick();
    check("mid_rel_in_ready", a_bus.in_ready, 1);
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    accept_block(blk, c0);
    wait_out(c0, lat);
    check("post_rst_latency", 128'(lat), 128'd13);
    check("post_rst_data", a_bus.data_out, blk + 128'(NR));
    tick();
    a_bus.out_ready = 1'b0;

`ifdef AES_SEQ_ZEROIZE_EN
    // Zeroize while holding a result.
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    accept_block(blk, c0);
    wait_out(c0, lat);
    check("zz_pre_data", a_bus.data_out, blk + 128'(NR));
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("zz_out_valid", a_bus.out_valid, 0);
    check("zz_data_out", a_bus.data_out, 0);
    check("zz_data_out1", a_bus.data_out1, 0);
    check("zz_dp_state_in", a_dp_in, 0);
    check("zz_busy", a_busy, 0);
    tick();
    check("zz_in_ready", a_bus.in_ready, 1);
`endif

    // ROUND_CYCLES=3 instance.
    blk = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_bus.in_valid = 1'b1;
    b_bus.data_in  = blk;
    b_bus.out_ready = 1'b1;
    for (int g = 0; g < 100 && !b_bus.in_ready; g++) tick();
    c0 = cyc;
    s0 = b_steps;
    tick();
    b_bus.in_valid = 1'b0;
    for (int g = 0; g < 400 && !b_bus.out_valid; g++) tick();
    check("rc3_latency", 128'(cyc - c0), 128'd33);
    check("rc3_data", b_bus.data_out, blk + 128'(NR));
    check("rc3_steps", 128'(b_steps - s0), 128'(NR));
    check("rc3_step_gap", 128'(b_gap_bad), 128'd0);
    tick();
    check("rc3_in_ready", b_bus.in_ready, 1);

    check("dp_last_round", 128'(last_bad), 128'd0);
    check("load_step_exclusive", 128'(excl_bad), 128'd0);
    check("step_outside_round", 128'(step_state_bad), 128'd0);
    check("in_ready_outside_idle", 128'(rdy_bad), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Control block that sequences an iterative AES round datapath for the 128-bit block path.
- Accepts one block per valid/ready handshake and loads it into the external round datapath.
- Steps the datapath through rounds 1..NUM_ROUNDS, then captures the result into an output register.
- Presents the result as one 128-bit word plus four 32-bit word slices.
- Owns the round counter, last-round (no MixColumns) flag and output handshake. Contains no cipher logic.

Parameters:
- NUM_ROUNDS, 10, number of datapath rounds after the initial AddRoundKey load (10 for AES-128).
- ROUND_CYCLES, 1, clock cycles per round; the datapath advances only on the last sub-cycle.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_in holds a block.
- in_ready  output  1  sequencer can accept a block.
- data_in  input  128  plaintext block.
- dp_state_in  output  128  block driven to the datapath; qualified by dp_load.
- dp_load  output  1  datapath loads dp_state_in and applies round-0 key.
- dp_step  output  1  datapath performs round dp_round at this edge.
- dp_round  output  4  current round index, 0..NUM_ROUNDS.
- dp_last  output  1  final round; datapath skips MixColumns.
- dp_state_out  input  128  datapath state register.
- out_valid  output  1  data_out holds a result.
- out_ready  input  1  consumer takes the result.
- data_out  output  128  result block.
- data_out1..data_out4  output  32 each  slices: data_out1=[127:96], data_out2=[95:64], data_out3=[63:32], data_out4=[31:0].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; rnd=0; sub=0.
- Reset also zeroes: in_ready, dp_state_in, dp_load, dp_step, dp_round, dp_last, out_valid, data_out (and all slices), busy.
- in_ready is a registered output. It is 0 only while reset is held and rises in the first cycle after reset release.
- States: IDLE, LOAD, ROUND, CAPT, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: register data_in into dp_state_in, then go to LOAD.
- LOAD (1 cycle):
  - dp_load=1, dp_round=0.
  - Next: ROUND with rnd=1, sub=0.
- ROUND:
  - dp_round=rnd; dp_last=(rnd==NUM_ROUNDS).
  - sub counts 0..ROUND_CYCLES-1.
  - dp_step=1 only when sub==ROUND_CYCLES-1. At that point sub wraps to 0 and rnd increments.
  - After the step with rnd==NUM_ROUNDS, go to CAPT.
- CAPT (1 cycle): data_out<=dp_state_out, then go to DONE.
- DONE:
  - out_valid=1; data_out is stable.
  - When out_ready: out_valid falls next cycle and state goes to IDLE.
- Latency with defaults: acceptance edge in cycle 0; LOAD in cycle 1; ROUND in cycles 2..11; CAPT in cycle 12; out_valid first high in cycle 13.
  - General formula: 3 + NUM_ROUNDS*ROUND_CYCLES cycles after acceptance.
- Throughput: one block per (4 + NUM_ROUNDS*ROUND_CYCLES) cycles at best.
- in_ready=0 everywhere except IDLE. in_valid outside IDLE is ignored; the block is not dropped silently because the producer holds it.
- out_ready while out_valid=0 has no effect.
- data_out keeps its last value after consumption until the next CAPT.
- dp_load and dp_step are never high in the same cycle. dp_step is never high outside ROUND.
- rnd is 4 bits; NUM_ROUNDS must be ≤15 (elaboration check).
- Reset mid-operation: immediate return to IDLE with all outputs zeroed. The datapath contents are don't-care until the next dp_load.

Optional Feature:
- Macro: AES_SEQ_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit, synchronous).
  - When zeroize=1 in any state: next cycle the block behaves exactly as after reset — state=IDLE, counters 0, dp_state_in, data_out and all slices 0, out_valid=0.
  - data_out is also cleared to 0 on the cycle after a DONE handshake.
- Not defined:
  - No zeroize port.
  - data_out retains the last result after the handshake.

Decomposition:
- Shared package aes_seq_pkg holds:
  - state enum encoding (IDLE=0, LOAD=1, ROUND=2, CAPT=3, DONE=4);
  - AES_BLOCK_W=128 and AES_WORD_W=32;
  - default round count constant AES128_ROUNDS=10.
- One sub-module, aes_round_counter: rnd/sub counters with step and last-round generation.
- FSM, data registers and handshakes remain in aes_round_sequencer.

Test Plan:
- Bench datapath model: loads on dp_load; adds 1 to the state on each dp_step.
- Single block:
  - Stimulus: data_in=128'h3243f6a8885a308d313198a2e0370734, out_ready=1.
  - Expected: out_valid rises 13 cycles after acceptance; data_out=...0734+10=128'h3243f6a8885a308d313198a2e037073e.
  - Expected: data_out1=32'h3243f6a8, data_out4=32'he037073e.
  - Expected: dp_step asserted exactly 10 times; dp_last high only with dp_round=10.
- Backpressure:
  - Stimulus: out_ready=0 for 20 cycles after out_valid.
  - Expected: data_out stable; in_ready=0 throughout.
  - Expected: after out_ready=1, in_ready=1 on the next cycle.
- Back-to-back:
  - Stimulus: blocks AB348DF80C51984E2790436287AB34D1 then ACD670231AB1984E2790436287AB34D1, in_valid held.
  - Expected: second acceptance exactly 14 cycles after the first; results are input+10 each.
- ROUND_CYCLES=3:
  - Expected: dp_step once every 3 cycles; out_valid 33 cycles after acceptance.
- Reset mid-ROUND:
  - Stimulus: reset=0 at round 5.
  - Expected: all outputs 0 asynchronously; in_ready=1 in the cycle after release; next block completes correctly.
- AES_SEQ_ZEROIZE_EN:
  - Stimulus: zeroize pulse while in DONE.
  - Expected: out_valid=0 and data_out=0 next cycle.
  - Expected: after a normal handshake, data_out reads 0 on the following cycle.
